// File: rtl/imem_word_loader.sv
// Loads a length-prefixed, XOR-checked byte stream into instruction memory as
// little-endian 32-bit words, holding the CPU in reset until a good frame completes.
module imem_word_loader #(
   parameter int unsigned AW      = 6,
   parameter int unsigned TIMEOUT = 24_000_000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    byte_in,
   input  logic          byte_valid,
   output logic          imem_we,
   output logic [AW-1:0] imem_addr,
   output logic [31:0]   imem_wdata,
   output logic          cpu_rst_n,
   output logic          done,
   output logic          err
);

   localparam int unsigned TW       = $clog2(TIMEOUT + 1);
   localparam int unsigned MaxWords = 2 ** AW;

   typedef enum logic [2:0] {
      StIdle, StLen, StData, StWrite, StChk, StDone, StErr
   } state_e;

   state_e        state_q, state_d;
   logic [7:0]    len_q, len_d;
   logic [8:0]    cnt_q, cnt_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [1:0]    idx_q, idx_d;
   logic [23:0]   asm_q, asm_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [7:0]    acc_q, acc_d;
   logic [TW-1:0] timer_q, timer_d;

   logic          take;
   logic [1:0]    idx_base;
   logic [7:0]    acc_base;
   logic          timing;
   logic          timeout;
   logic          len_bad;

   assign len_bad = (len_q == 8'd0) || (32'(len_q) > MaxWords);
   assign timing  = (state_q == StLen) || (state_q == StData) ||
                    (state_q == StWrite) || (state_q == StChk);
   assign timeout = (timer_q == TW'(TIMEOUT - 1));

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      idx_d    = idx_q;
      asm_d    = asm_q;
      wdata_d  = wdata_q;
      acc_d    = acc_q;
      take     = 1'b0;
      idx_base = idx_q;
      acc_base = acc_q;

      if (!timing || byte_valid) begin
         timer_d = '0;
      end else begin
         timer_d = timer_q + TW'(1);
      end

      case (state_q)
         StIdle, StDone, StErr: begin
            if (byte_valid) begin
               len_d   = byte_in;
               state_d = StLen;
            end
         end
         StLen: begin
            if (len_bad) begin
               state_d = StErr;
            end else begin
               cnt_d    = {1'b0, len_q};
               addr_d   = '0;
               idx_d    = '0;
               acc_d    = '0;
               idx_base = '0;
               acc_base = '0;
               state_d  = StData;
               take     = byte_valid;
            end
         end
         StData: take = byte_valid;
         StWrite: begin
            addr_d = addr_q + AW'(1);
            cnt_d  = cnt_q - 9'd1;
            if (cnt_q == 9'd1) begin
               state_d = StChk;
               // A byte in this cycle is already the checksum.
               if (byte_valid) state_d = (byte_in == acc_q) ? StDone : StErr;
            end else begin
               state_d = StData;
               take    = byte_valid;
            end
         end
         StChk: begin
            if (byte_valid) state_d = (byte_in == acc_q) ? StDone : StErr;
         end
         default: state_d = StIdle;
      endcase

      if (take) begin
         acc_d = acc_base ^ byte_in;
         idx_d = idx_base + 2'd1;
         case (idx_base)
            2'd0: asm_d[7:0]   = byte_in;
            2'd1: asm_d[15:8]  = byte_in;
            2'd2: asm_d[23:16] = byte_in;
            default: begin
               wdata_d = {byte_in, asm_q};
               state_d = StWrite;
            end
         endcase
      end

      if (timing && !byte_valid && timeout) state_d = StErr;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StIdle;
         len_q   <= '0;
         cnt_q   <= '0;
         addr_q  <= '0;
         idx_q   <= '0;
         asm_q   <= '0;
         wdata_q <= '0;
         acc_q   <= '0;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         idx_q   <= idx_d;
         asm_q   <= asm_d;
         wdata_q <= wdata_d;
         acc_q   <= acc_d;
         timer_q <= timer_d;
      end
   end

   // Gate with rst so no write strobe is seen while reset is being applied.
   assign imem_we    = (state_q == StWrite) && rst;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign cpu_rst_n  = (state_q == StDone);
   assign done       = (state_q == StDone);
   assign err        = (state_q == StErr);

endmodule

// File: doc/imem_word_loader.md
IMEM_WORD_LOADER -- requirements
Module: imem_word_loader

Interface
REQ-001 Parameter: AW, 6, instruction-memory word-address width (64 words).
REQ-002 Parameter: TIMEOUT, 24_000_000, max clk cycles between consecutive bytes of one frame.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 byte_in  input  8  received payload byte from the UART receive stage; valid only when byte_valid=1.
REQ-006 byte_valid  input  1  single-cycle strobe, one per byte; no backpressure.
REQ-007 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-008 imem_addr  output  AW  instruction-memory word address.
REQ-009 imem_wdata  output  32  assembled instruction word.
REQ-010 cpu_rst_n  output  1  CPU/PC reset, active-low; 0 holds the CPU.
REQ-011 done  output  1  level: last load completed with a good checksum.
REQ-012 err  output  1  level: last load aborted (length, checksum or timeout).

Function
REQ-013 Frame format shall be: LEN byte N (words), then 4*N data bytes, then CHK byte.
REQ-014 Each word shall be assembled little-endian: byte 0 -> [7:0], byte 3 -> [31:24].
REQ-015 CHK shall equal the XOR of all 4*N data bytes; LEN is excluded.
REQ-016 FSM states: IDLE, LEN, DATA, WRITE, CHK, DONE, ERR.
REQ-017 IDLE: first byte_valid shall be taken as LEN, processed as in REQ-018; no separate start byte.
REQ-018 LEN handling: N=0 or N>2**AW shall go to ERR; otherwise word counter=N, address=0, byte index=0, xor accumulator=0, go to DATA.
REQ-019 DATA: each byte_valid shall shift into the assembly register at the byte index and XOR into the accumulator.
REQ-020 The 4th byte of a word shall move to WRITE next cycle; imem_we=1 for exactly that one cycle with the completed imem_wdata and current imem_addr.
REQ-021 WRITE shall increment imem_addr (modulo 2**AW) and decrement the word counter, then go to DATA, or to CHK when the counter reaches 0.
REQ-022 A byte_valid arriving in the WRITE cycle shall be accepted as byte 0 of the next word (or as CHK), and not dropped.
REQ-023 CHK: byte equal to accumulator -> DONE; mismatch -> ERR.
REQ-024 Inter-byte timer shall clear on every byte_valid and count in LEN/DATA/WRITE/CHK; reaching TIMEOUT shall go to ERR.
REQ-025 cpu_rst_n shall be 0 in every state except DONE; it rises the cycle DONE is entered.
REQ-026 done=1 only in DONE; err=1 only in ERR.
REQ-027 In DONE or ERR, a byte_valid shall start a new frame (taken as LEN), clear done/err, and drive cpu_rst_n=0 in the same transition.
REQ-028 Words already written before an ERR shall not be rolled back; the CPU stays held.
REQ-029 imem_we shall never assert outside WRITE; imem_addr/imem_wdata hold their values between writes.

Reset
REQ-030 rst=0 shall force IDLE, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst_n=0, done=0, err=0, all counters and the accumulator to 0.
REQ-031 Reset asserted mid-frame shall abort it within one cycle; no imem_we after the reset edge.

Verification
REQ-032 LEN=1, bytes 13 05 00 00, CHK=16 -> one imem_we, addr 0, wdata 0x00000513; done=1, cpu_rst_n=1.
REQ-033 LEN=2, words 0x00100093/0x00208113, correct CHK -> writes at addr 0 then 1; done=1.
REQ-034 LEN=1, good data, CHK off by 0x01 -> one write then err=1, done=0, cpu_rst_n=0.
REQ-035 LEN=0, and separately LEN=65 -> err=1 immediately, no imem_we.
REQ-036 LEN=2, stop after 5 data bytes -> err=1 exactly TIMEOUT cycles after the last byte; exactly one write.
REQ-037 Back-to-back: byte_valid in the WRITE cycle is not lost; after DONE, a new frame drops cpu_rst_n on LEN, and rst=0 mid-DATA returns all outputs to reset values.
